alu_mul_seq: RTL

- Multi-cycle controller that computes a WIDTH-bit multiply (low WIDTH bits of op_a*op_b, RISC-V MUL semantics) by sequencing the shared 64-bit ALU with shift-and-add.
- It uses the ALU's ADD, SLL, SRL and OR operations and its zero flag.
- It owns the ALU operand/op inputs for the whole operation and releases them to a fixed idle value between operations.

---
 rtl/alu_mul_seq_if.sv | 20 ++
 rtl/alu_mul_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/alu_mul_seq_if.sv
// Request/response bus between a requester and the sequential multiplier.
//   start   : request, honoured only while ready=1
//   op_a    : multiplicand, captured on an accepted start
//   op_b    : multiplier, captured on an accepted start
//   ready   : controller idle and able to accept a request
//   done    : one-cycle pulse; product is valid
//   product : low WIDTH bits of op_a*op_b; held until the next accepted start
interface alu_mul_seq_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] product;

  modport master (output start, op_a, op_b, input ready, done, product);
  modport slave  (input start, op_a, op_b, output ready, done, product);
endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-and-add multiplier that sequences a shared combinational
// ALU. It computes the low WIDTH bits of op_a*op_b using the ALU's ADD, SLL,
// SRL and OR operations plus its zero flag, and ends early once the remaining
// multiplier bits are all zero.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : request/response bus (start, op_a, op_b, ready, done, product)
//   alu_a      : ALU operand A (zero between operations)
//   alu_b      : ALU operand B (zero between operations)
//   alu_op     : ALU operation select (3'b000 between operations)
//   alu_result : ALU combinational result
//   alu_zero   : ALU zero flag
module alu_mul_seq #(
  parameter int          WIDTH  = 64,
  parameter logic [2:0]  OP_ADD = 3'b010,
  parameter logic [2:0]  OP_OR  = 3'b001,
  parameter logic [2:0]  OP_SLL = 3'b011,
  parameter logic [2:0]  OP_SRL = 3'b111
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_mul_seq_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TEST,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  // ALU drive is registered: each transition loads the operands the next
  // state needs, so alu_a/alu_b/alu_op are valid for the whole state.
  // Entering TEST from SHR uses alu_result directly since mplier is being
  // updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mcand       <= '0;
      mplier      <= '0;
      bus.product <= '0;
      bus.ready   <= 1'b1;
      bus.done    <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= 3'b000;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            mcand       <= bus.op_a;
            mplier      <= bus.op_b;
            bus.product <= '0;
            bus.ready   <= 1'b0;
            state       <= S_TEST;
            alu_op      <= OP_OR;
            alu_a       <= bus.op_b;
            alu_b       <= '0;
          end
        end

        S_TEST: begin
          if (alu_zero) begin
            state    <= S_DONE;
            bus.done <= 1'b1;
            alu_op   <= 3'b000;
            alu_a    <= '0;
            alu_b    <= '0;
          end else if (mplier[0]) begin
            state  <= S_ADD;
            alu_op <= OP_ADD;
            alu_a  <= bus.product;
            alu_b  <= mcand;
          end else begin
            state  <= S_SHL;
            alu_op <= OP_SLL;
            alu_a  <= mcand;
            alu_b  <= WIDTH'(1);
          end
        end

        S_ADD: begin
          bus.product <= alu_result;
          state       <= S_SHL;
          alu_op      <= OP_SLL;
          alu_a       <= mcand;
          alu_b       <= WIDTH'(1);
        end

        S_SHL: begin
          mcand  <= alu_result;
          state  <= S_SHR;
          alu_op <= OP_SRL;
          alu_a  <= mplier;
          alu_b  <= WIDTH'(1);
        end

        S_SHR: begin
          mplier <= alu_result;
          state  <= S_TEST;
          alu_op <= OP_OR;
          alu_a  <= alu_result;
          alu_b  <= '0;
        end

        S_DONE: begin
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          bus.done  <= 1'b0;
          bus.ready <= 1'b1;
          alu_op    <= 3'b000;
          alu_a     <= '0;
          alu_b     <= '0;
        end
      endcase
    end
  end

endmodule
